fx2_response_tx: RTL and testbench

Transmit-side counterpart of the FX2 command receiver. Takes 16-bit response words from the core over a four-phase req/ack handshake and writes them into an FX2 slave-FIFO IN endpoint. It drives SLWR/PKTEND and respects the endpoint full flag. Short packets are committed by explicit PKTEND on a `last` word, or by an idle-timeout flush. It shares the FD bus with the receive path under an external grant, and runs entirely in the `fx2_ifclk` domain.

---
 rtl/fx2_response_tx.sv | 162 ++++++++++++++++
 tb/tb_fx2_response_tx.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/fx2_response_tx.sv
// fx2_response_tx
// Takes 16-bit response words from the core over a four-phase req/ack
// handshake and writes them into an FX2 slave-FIFO IN endpoint. Short packets
// are committed with PKTEND either on a word flagged `last` or after an idle
// timeout. Every output is registered and is derived from the next state, so
// a strobe is asserted during exactly the cycle spent in the matching state.
module fx2_response_tx #(
    parameter logic [1:0] FIFOADDR     = 2'b10,
    parameter int         PKT_WORDS    = 256,
    parameter int         IDLE_TIMEOUT = 64
) (
    input  logic        fx2_ifclk,
    input  logic        reset,
    input  logic        fx2_full_n,
    input  logic        bus_grant,
    output logic        fx2_slwr,
    output logic        fx2_pktend,
    output logic [1:0]  fx2_fifoaddr,
    output logic [15:0] fx2_fd_out,
    output logic        fx2_fd_oe,
    output logic        tx_busy,
    input  logic [15:0] response_tx_data,
    input  logic        response_tx_last,
    input  logic        response_tx_req,
    output logic        response_tx_ack
);

    // Word counter spans exactly one USB packet, so it wraps where the FX2
    // auto-commits.
    localparam int CW = (PKT_WORDS > 1) ? $clog2(PKT_WORDS) : 1;
    // Idle counter only needs to reach IDLE_TIMEOUT-1, where it saturates.
    localparam int IW = (IDLE_TIMEOUT > 1) ? $clog2(IDLE_TIMEOUT) : 1;
    localparam int IDLE_MAX_I = (IDLE_TIMEOUT > 0) ? IDLE_TIMEOUT - 1 : 0;
    localparam logic [IW-1:0] IDLE_MAX = IDLE_MAX_I[IW-1:0];

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WRITE,
        ST_PKTEND,
        ST_FLUSH,
        ST_ACK_WAIT
    } state_t;

    state_t         state_reg,  state_next;
    logic [CW-1:0]  count_reg,  count_next;
    logic [IW-1:0]  idle_reg,   idle_next;
    logic           last_reg,   last_next;
    logic [15:0]    data_reg,   data_next;
    logic           slwr_reg,   slwr_next;
    logic           pktend_reg, pktend_next;
    logic           oe_reg,     oe_next;
    logic           busy_reg,   busy_next;
    logic           ack_reg,    ack_next;

    logic           accept;
    logic           flush_due;

    // Next-state, counters and registered-output values.
    always_comb begin
        state_next = state_reg;
        count_next = count_reg;
        idle_next  = idle_reg;
        last_next  = last_reg;
        data_next  = data_reg;

        // A new word is taken only when the previous handshake has fully
        // completed and the FX2 can take it right now.
        accept = response_tx_req & ~ack_reg & bus_grant & fx2_full_n;
        // A request in the same cycle always beats the timeout.
        flush_due = (IDLE_TIMEOUT != 0) && !response_tx_req &&
                    (count_reg != '0) && (idle_reg == IDLE_MAX) && bus_grant;

        case (state_reg)
            ST_IDLE: begin
                if (accept) begin
                    state_next = ST_WRITE;
                    data_next  = response_tx_data;
                    last_next  = response_tx_last;
                    count_next = count_reg + CW'(1);
                end else if (flush_due) begin
                    state_next = ST_FLUSH;
                end
            end
            ST_WRITE: begin
                // A count of zero here means the word filled the packet and
                // the FX2 has already committed it; no zero-length packet.
                if (last_reg && (count_reg != '0)) begin
                    state_next = ST_PKTEND;
                end else begin
                    state_next = ST_ACK_WAIT;
                end
            end
            ST_PKTEND: begin
                count_next = '0;
                state_next = ST_ACK_WAIT;
            end
            ST_FLUSH: begin
                count_next = '0;
                state_next = ST_IDLE;
            end
            ST_ACK_WAIT: begin
                if (!response_tx_req) begin
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase

        // Idle time is measured from the last strobe or ack release; it is
        // kept at zero while anything is happening or a request is pending.
        if ((IDLE_TIMEOUT == 0) || (state_reg != ST_IDLE) || response_tx_req) begin
            idle_next = '0;
        end else if (idle_reg != IDLE_MAX) begin
            idle_next = idle_reg + IW'(1);
        end

        slwr_next   = (state_next != ST_WRITE);
        pktend_next = !((state_next == ST_PKTEND) || (state_next == ST_FLUSH));
        oe_next     = (state_next == ST_WRITE);
        busy_next   = (state_next != ST_IDLE);
        ack_next    = (state_next == ST_WRITE) || (state_next == ST_PKTEND) ||
                      (state_next == ST_ACK_WAIT);
    end

    // State, counters and output registers; reset drops any word in flight.
    always_ff @(posedge fx2_ifclk or posedge reset) begin
        if (reset) begin
            state_reg  <= ST_IDLE;
            count_reg  <= '0;
            idle_reg   <= '0;
            last_reg   <= 1'b0;
            data_reg   <= '0;
            slwr_reg   <= 1'b1;
            pktend_reg <= 1'b1;
            oe_reg     <= 1'b0;
            busy_reg   <= 1'b0;
            ack_reg    <= 1'b0;
        end else begin
            state_reg  <= state_next;
            count_reg  <= count_next;
            idle_reg   <= idle_next;
            last_reg   <= last_next;
            data_reg   <= data_next;
            slwr_reg   <= slwr_next;
            pktend_reg <= pktend_next;
            oe_reg     <= oe_next;
            busy_reg   <= busy_next;
            ack_reg    <= ack_next;
        end
    end

    assign fx2_slwr        = slwr_reg;
    assign fx2_pktend      = pktend_reg;
    assign fx2_fifoaddr    = FIFOADDR;
    assign fx2_fd_out      = data_reg;
    assign fx2_fd_oe       = oe_reg;
    assign tx_busy         = busy_reg;
    assign response_tx_ack = ack_reg;

endmodule

// File: tb/tb_fx2_response_tx.sv
// Bench for fx2_response_tx: directed handshakes against a default instance
// and a second instance with the idle flush disabled. Written words are
// queued when driven and compared when the DUT strobes SLWR.
module tb_fx2_response_tx;

    logic        clk = 1'b0;
    logic        reset;
    logic        full_n;
    logic        grant;
    logic [15:0] data;
    logic        last;
    logic        req;
    logic        req0;

    logic        slwr, pktend, oe, busy, ack;
    logic [1:0]  fifoaddr;
    logic [15:0] fd_out;

    logic        slwr0, pktend0, oe0, busy0, ack0;
    logic [1:0]  fifoaddr0;
    logic [15:0] fd_out0;

    int checks = 0;
    int errors = 0;
    int slwr_pulses = 0;
    int pkt_pulses = 0;
    int pkt0_pulses = 0;
    int slwr0_pulses = 0;
    logic [15:0] exp_q[$];

    always #5 clk = ~clk;

    fx2_response_tx dut (
        .fx2_ifclk(clk), .reset(reset), .fx2_full_n(full_n), .bus_grant(grant),
        .fx2_slwr(slwr), .fx2_pktend(pktend), .fx2_fifoaddr(fifoaddr),
        .fx2_fd_out(fd_out), .fx2_fd_oe(oe), .tx_busy(busy),
        .response_tx_data(data), .response_tx_last(last),
        .response_tx_req(req), .response_tx_ack(ack)
    );

    fx2_response_tx #(.IDLE_TIMEOUT(0)) dut0 (
        .fx2_ifclk(clk), .reset(reset), .fx2_full_n(full_n), .bus_grant(grant),
        .fx2_slwr(slwr0), .fx2_pktend(pktend0), .fx2_fifoaddr(fifoaddr0),
        .fx2_fd_out(fd_out0), .fx2_fd_oe(oe0), .tx_busy(busy0),
        .response_tx_data(data), .response_tx_last(last),
        .response_tx_req(req0), .response_tx_ack(ack0)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Bounded wait at falling edges for ack (sel=0) or ack0 (sel=1) to reach
    // `want`; lat is the number of falling edges taken, 99 on timeout.
    task automatic wait_ack(input logic want, input bit sel, output int lat);
        lat = 99;
        for (int i = 1; i <= 50; i++) begin
            @(negedge clk);
            if (((sel ? ack0 : ack) === want)) begin
                lat = i;
                break;
            end
        end
    endtask

    // Full four-phase handshake of one word on the default instance.
    task automatic send_word(input logic [15:0] d, input logic l, input logic exp_pkt);
        int lat;
        @(posedge clk); #1;
        data = d; last = l; req = 1'b1;
        exp_q.push_back(d);
        wait_ack(1'b1, 1'b0, lat);
        check("ack_latency", lat, 2);
        check("slwr_with_ack", slwr, 1'b0);
        check("busy_in_write", busy, 1'b1);
        @(negedge clk);
        check("slwr_one_cycle", slwr, 1'b1);
        check("pktend_after_write", pktend, exp_pkt ? 1'b0 : 1'b1);
        @(posedge clk); #1;
        req = 1'b0;
        wait_ack(1'b0, 1'b0, lat);
        check("ack_fall", lat < 99, 1'b1);
    endtask

    // Scoreboard side: every SLWR cycle must carry the oldest queued word.
    always @(negedge clk) begin
        if (slwr === 1'b0) begin
            slwr_pulses++;
            check("wr_expected", exp_q.size() != 0, 1'b1);
            if (exp_q.size() != 0) begin
                check("wr_data", fd_out, exp_q.pop_front());
                check("wr_oe", oe, 1'b1);
            end
        end
        if (pktend === 1'b0) pkt_pulses++;
        if (pktend0 === 1'b0) pkt0_pulses++;
        if (slwr0 === 1'b0) slwr0_pulses++;
    end

    initial begin
        int lat;
        int p;
        int s;
        int k;

        reset = 1'b1; full_n = 1'b1; grant = 1'b1;
        data = '0; last = 1'b0; req = 1'b0; req0 = 1'b0;

        // Reset values
        repeat (2) @(negedge clk);
        check("rst_slwr", slwr, 1'b1);
        check("rst_pktend", pktend, 1'b1);
        check("rst_fifoaddr", fifoaddr, 2'b10);
        check("rst_fd_out", fd_out, 16'h0000);
        check("rst_oe", oe, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_ack", ack, 1'b0);
        @(posedge clk); #1;
        reset = 1'b0;
        repeat (3) @(negedge clk);

        // Single partial word, then idle-timeout flush after 64 cycles
        p = pkt_pulses;
        send_word(16'hA5A5, 1'b0, 1'b0);
        k = 0;
        for (int i = 1; i <= 100; i++) begin
            @(negedge clk);
            if (pktend === 1'b0) begin
                k = i;
                break;
            end
        end
        check("flush_delay", k, 64);
        @(negedge clk);
        check("flush_one_cycle", pktend, 1'b1);
        repeat (150) @(negedge clk);
        check("flush_count", pkt_pulses - p, 1);

        // Three words, last on the third: explicit PKTEND, no later flush
        p = pkt_pulses;
        s = slwr_pulses;
        send_word(16'h0001, 1'b0, 1'b0);
        send_word(16'h0002, 1'b0, 1'b0);
        send_word(16'h0003, 1'b1, 1'b1);
        repeat (150) @(negedge clk);
        check("three_slwr", slwr_pulses - s, 3);
        check("three_pktend", pkt_pulses - p, 1);

        // Full packet of 256 words, last on the final one: no PKTEND
        p = pkt_pulses;
        s = slwr_pulses;
        for (int w = 0; w < 256; w++) begin
            send_word(w[15:0], w == 255, 1'b0);
        end
        repeat (150) @(negedge clk);
        check("full_slwr", slwr_pulses - s, 256);
        check("full_no_pktend", pkt_pulses - p, 0);

        // Endpoint full stalls the request; write follows release by one edge
        @(posedge clk); #1;
        full_n = 1'b0; data = 16'h1234; last = 1'b1; req = 1'b1;
        exp_q.push_back(16'h1234);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("full_stall_slwr", slwr, 1'b1);
            check("full_stall_ack", ack, 1'b0);
        end
        @(posedge clk); #1;
        full_n = 1'b1;
        @(negedge clk);
        check("full_release_wait", slwr, 1'b1);
        @(negedge clk);
        check("full_release_slwr", slwr, 1'b0);
        check("full_release_ack", ack, 1'b1);
        @(negedge clk);
        check("full_release_pktend", pktend, 1'b0);
        @(posedge clk); #1;
        req = 1'b0;
        wait_ack(1'b0, 1'b0, lat);
        check("full_ack_fall", lat < 99, 1'b1);

        // Bus not granted stalls; then reset in the middle of WRITE
        @(posedge clk); #1;
        grant = 1'b0; data = 16'hBEEF; last = 1'b0; req = 1'b1;
        exp_q.push_back(16'hBEEF);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("grant_stall_slwr", slwr, 1'b1);
            check("grant_stall_ack", ack, 1'b0);
        end
        @(posedge clk); #1;
        grant = 1'b1;
        @(posedge clk); #1;
        check("grant_write_slwr", slwr, 1'b0);
        check("grant_write_ack", ack, 1'b1);
        #1;
        reset = 1'b1;
        #1;
        check("async_rst_slwr", slwr, 1'b1);
        check("async_rst_oe", oe, 1'b0);
        check("async_rst_ack", ack, 1'b0);
        check("async_rst_busy", busy, 1'b0);
        req = 1'b0;
        exp_q.delete();
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        p = pkt_pulses;
        s = slwr_pulses;
        repeat (150) @(negedge clk);
        check("post_rst_no_pktend", pkt_pulses - p, 0);
        check("post_rst_no_slwr", slwr_pulses - s, 0);

        // Flush disabled instance: one partial word, never a PKTEND
        @(posedge clk); #1;
        data = 16'h0F0F; last = 1'b0; req0 = 1'b1;
        wait_ack(1'b1, 1'b1, lat);
        check("t0_ack_latency", lat, 2);
        check("t0_slwr", slwr0, 1'b0);
        check("t0_data", fd_out0, 16'h0F0F);
        @(posedge clk); #1;
        req0 = 1'b0;
        wait_ack(1'b0, 1'b1, lat);
        check("t0_ack_fall", lat < 99, 1'b1);
        repeat (1000) @(negedge clk);
        check("t0_no_pktend", pkt0_pulses, 0);
        check("t0_slwr_count", slwr0_pulses, 1);

        check("queue_empty", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
